// File: rtl/jtkunio_pcm_pkg.sv
// rtl/jtkunio_pcm_pkg.sv - shared constants for the Kunio PCM sample fetcher
package jtkunio_pcm_pkg;

  localparam int AW_DEF      = 17;
  localparam int CNTW_DEF    = 13;
  localparam int FIFO_AW_DEF = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam logic [2:0] BANK_0 = 3'b001;
  localparam logic [2:0] BANK_1 = 3'b010;
  localparam logic [2:0] BANK_2 = 3'b100;

  // Malformed one-hot values fall back to bank 0
  function automatic logic [1:0] bank_idx(input logic [2:0] bank);
    case (bank)
      BANK_1:  return 2'd1;
      BANK_2:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/jtkunio_pcm_if.sv
// rtl/jtkunio_pcm_if.sv - PCM ROM request bus (rom_cs/rom_ok handshake)
interface jtkunio_pcm_if
  import jtkunio_pcm_pkg::*;
#(
  parameter int AW = AW_DEF
);
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [7:0]    rom_data;
  logic          rom_ok;

  modport master (output rom_addr, rom_cs, input rom_data, rom_ok);
  modport slave  (input rom_addr, rom_cs, output rom_data, rom_ok);
endinterface

// File: rtl/jtkunio_pcm_fifo.sv
// rtl/jtkunio_pcm_fifo.sv - first-word-fall-through byte FIFO for PCM data
module jtkunio_pcm_fifo
  import jtkunio_pcm_pkg::*;
#(
  parameter int AW = FIFO_AW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  logic [7:0]    mem [2**AW];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = cnt[AW];
  assign empty   = (cnt == '0);
  assign head    = mem[rptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/jtkunio_pcm_fetch.sv
// rtl/jtkunio_pcm_fetch.sv - walks one PCM block in ROM and feeds nibbles to the ADPCM decoder
module jtkunio_pcm_fetch
  import jtkunio_pcm_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int CNTW    = CNTW_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] bank,
  input  logic [1:0] msb,
  input  logic       nib_req,
  output logic [3:0] nib_dout,
  output logic       dec_rst,
  output logic       nmi_n,
  output logic       underrun,
  jtkunio_pcm_if.master rom
);
  logic [1:0]  st, bidx, msb_q;
  logic        active, waited;
  logic [CNTW:0] fcnt, ncnt;
  logic        fifo_full, fifo_empty, halt, accept, push, pop;
  logic [7:0]  head;

  assign halt   = start || stop;
  assign accept = (st == ST_WAIT) && waited && rom.rom_ok;
  assign push   = accept && !halt;
  assign pop    = nib_req && active && !halt && !fifo_empty && ncnt[0];

  assign rom.rom_cs   = (st == ST_REQ) || (st == ST_WAIT);
  assign rom.rom_addr = AW'({bidx, msb_q, fcnt[CNTW-1:0]});

  jtkunio_pcm_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (halt),
    .push  (push),
    .pop   (pop),
    .din   (rom.rom_data),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // waited masks an ok left over from the previous request in the first WAIT cycle
  always_ff @(posedge clk) begin
    if (rst || halt) begin
      st     <= ST_IDLE;
      waited <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: if (active && !fifo_full && !fcnt[CNTW]) st <= ST_REQ;
        ST_REQ: begin
          st     <= ST_WAIT;
          waited <= 1'b0;
        end
        ST_WAIT: begin
          waited <= 1'b1;
          if (accept) st <= ST_GAP;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt     <= '0;
      ncnt     <= '0;
      active   <= 1'b0;
      dec_rst  <= 1'b1;
      nmi_n    <= 1'b1;
      underrun <= 1'b0;
      nib_dout <= 4'd0;
      bidx     <= 2'd0;
      msb_q    <= 2'd0;
    end else if (start) begin
      bidx     <= bank_idx(bank);
      msb_q    <= msb;
      fcnt     <= '0;
      ncnt     <= '0;
      underrun <= 1'b0;
      active   <= 1'b1;
      dec_rst  <= 1'b0;
      nmi_n    <= 1'b1;
    end else if (stop) begin
      active  <= 1'b0;
      dec_rst <= 1'b1;
      nmi_n   <= 1'b1;
    end else begin
      if (push) fcnt <= fcnt + (CNTW+1)'(1);
      if (nib_req && active) begin
        if (fifo_empty) begin
          underrun <= 1'b1;
        end else begin
          nib_dout <= ncnt[0] ? head[7:4] : head[3:0];
          ncnt     <= ncnt + (CNTW+1)'(1);
          if (&ncnt) begin
            active  <= 1'b0;
            nmi_n   <= 1'b0;
            dec_rst <= 1'b1;
          end
        end
      end
    end
  end

endmodule
